trigger_capture_ctrl: RTL and testbench
=======================================

TRIGGER_CAPTURE_CTRL -- requirements
Module: trigger_capture_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16, sets the width of beat counters, pre/post counts and trig_addr.
REQ-002 stream_clk  in  1  single clock for all logic.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 s_tvalid in 1; s_tready out 1; s_tdata in 32: AXI4-Stream slave carrying sample beats (ch2 in [31:16], ch1 in [15:0]).
REQ-005 m_tvalid out 1; m_tready in 1; m_tdata out 32; m_tlast out 1: AXI4-Stream master toward capture DMA.
REQ-006 ch1_rising, ch1_falling, ch2_rising, ch2_falling  in  1 each: per-beat level-trigger events, valid with the current s_tdata beat.
REQ-007 trig_sel  in  2  source select: 0 = ch1_rising, 1 = ch1_falling, 2 = ch2_rising, 3 = ch2_falling.
REQ-008 trig_force  in  1  software trigger, level-sensitive.
REQ-009 arm  in  1  single-cycle start pulse; abort  in  1  single-cycle cancel pulse.
REQ-010 pre_count, post_count  in  CNT_WIDTH each: pre-trigger and post-trigger beat counts.
REQ-011 busy out 1; done out 1; trig_addr out CNT_WIDTH: beat index of the trigger beat.

Function
REQ-012 States: IDLE, PRE, ARMED, POST, DONE; all transitions are registered.
REQ-013 A beat is "transferred" when s_tvalid and s_tready are both high.
REQ-014 IDLE/DONE: s_tready = 1, m_tvalid = 0, m_tlast = 0; input beats are discarded.
REQ-015 PRE/ARMED/POST: combinational pass-through with zero latency: m_tvalid = s_tvalid, s_tready = m_tready, m_tdata = s_tdata.
REQ-016 arm in IDLE or DONE latches pre_count, post_count and trig_sel, clears beat_cnt and done, and enters PRE; or ARMED if the latched pre_count = 0.
REQ-017 arm while busy is ignored; config inputs are ignored except at arm.
REQ-018 beat_cnt increments by one per transferred beat in PRE/ARMED/POST and wraps modulo 2^CNT_WIDTH.
REQ-019 PRE: the transition to ARMED occurs on the clock edge after the transfer that makes pre-beats-forwarded = pre_count; triggers are ignored in PRE.
REQ-020 ARMED: trigger = (selected event OR trig_force) on a transferred beat; on that edge trig_addr <= beat_cnt of the trigger beat and the state becomes POST; the trigger beat counts as post beat 1.
REQ-021 ARMED with no transfer: trigger inputs are ignored.
REQ-022 POST: m_tlast = 1 on the beat completing post_count post beats, with the trigger beat included; that transfer moves the state to DONE.
REQ-023 post_count = 0 is treated as 1: the trigger beat carries m_tlast and the state goes directly to DONE.
REQ-024 m_tlast is held, with data, until the beat is transferred (m_tready stall).
REQ-025 busy = 1 in PRE, ARMED and POST; done = 1 only in DONE.
REQ-026 abort has priority over arm and trigger: the state returns to IDLE on the next edge and done stays 0.
REQ-027 A beat transferring in the abort cycle passes through with m_tlast = 0.
REQ-028 trig_addr holds its value until the next trigger; it is not cleared by arm or abort.

Reset
REQ-029 resetn low asynchronously forces state IDLE; beat_cnt, latched config, trig_addr, busy and done reset to 0.
REQ-030 During reset, outputs are s_tready = 1, m_tvalid = 0 and m_tlast = 0.
REQ-031 Reset deassertion is synchronised to stream_clk before the first state transition.
REQ-032 Reset mid-capture discards the capture and emits no m_tlast.

Structure
REQ-033 Shared package trigger_capture_pkg holds the state enumeration, the trig_sel encodings and the default CNT_WIDTH.
REQ-034 The block is a single module with no sub-module; the source select is an inline mux.

Verification
REQ-035 pre=4, post=8, sel=0, ch1_rising on beat 10, m_tready=1 -> trig_addr=10, m_tlast on beat 17, 18 beats forwarded, done=1.
REQ-036 pre=4, ch1_rising pulsed on beats 2 and 6 -> beat 2 ignored, trig_addr=6.
REQ-037 pre=0, post=0, trig_force high at arm -> beat 0 forwarded with m_tlast=1, trig_addr=0, DONE.
REQ-038 Random m_tready/s_tvalid stalls during POST, post=5 -> exactly 5 post beats, m_tlast stable while stalled, no data loss.
REQ-039 abort in ARMED with a simultaneous transfer -> beat forwarded with m_tlast=0, IDLE next cycle, busy=0, done=0.
REQ-040 CNT_WIDTH=4, pre=0, trigger on beat 20 -> trig_addr=4 (wrap).

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// Shared types for the trigger capture controller: FSM states, source selects
// and the default counter width.
package trigger_capture_pkg;

  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_CH1_RISE = 2'd0,
    SEL_CH1_FALL = 2'd1,
    SEL_CH2_RISE = 2'd2,
    SEL_CH2_FALL = 2'd3
  } trig_sel_t;

endpackage

// File: rtl/trigger_capture_ctrl.sv
// Pre/post-trigger capture window on an AXI4-Stream sample path; beats inside
// the window pass straight through to the capture DMA, the rest are dropped.
//
// state  | meaning
// IDLE   | waiting for arm, input beats discarded
// PRE    | forwarding pre-trigger beats, triggers ignored
// ARMED  | forwarding, waiting for selected event or trig_force
// POST   | forwarding post-trigger beats until m_tlast
// DONE   | capture complete, beats discarded until next arm
module trigger_capture_ctrl
  import trigger_capture_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 stream_clk,
  input  logic                 resetn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [31:0]          s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [31:0]          m_tdata,
  output logic                 m_tlast,
  input  logic                 ch1_rising,
  input  logic                 ch1_falling,
  input  logic                 ch2_rising,
  input  logic                 ch2_falling,
  input  logic [1:0]           trig_sel,
  input  logic                 trig_force,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] pre_count,
  input  logic [CNT_WIDTH-1:0] post_count,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] trig_addr
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] pre_left_q, pre_left_d;
  logic [CNT_WIDTH-1:0] post_left_q, post_left_d;
  logic [CNT_WIDTH-1:0] trig_addr_q, trig_addr_d;
  trig_sel_t            sel_q, sel_d;
  logic                 passthru;
  logic                 xfer;
  logic                 sel_evt;
  logic                 trig_hit;
  logic                 last_post;

  // Assertion is immediate through the async clear; release waits two edges.
  always_ff @(posedge stream_clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  always_ff @(posedge stream_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      pre_left_q  <= '0;
      post_left_q <= '0;
      trig_addr_q <= '0;
      sel_q       <= SEL_CH1_RISE;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pre_left_q  <= pre_left_d;
      post_left_q <= post_left_d;
      trig_addr_q <= trig_addr_d;
      sel_q       <= sel_d;
    end
  end

  always_comb begin
    sel_evt = 1'b0;
    case (sel_q)
      SEL_CH1_RISE: sel_evt = ch1_rising;
      SEL_CH1_FALL: sel_evt = ch1_falling;
      SEL_CH2_RISE: sel_evt = ch2_rising;
      SEL_CH2_FALL: sel_evt = ch2_falling;
      default:      sel_evt = 1'b0;
    endcase
  end

  // m_tlast uses s_tvalid rather than the handshake so it stays stable under
  // an m_tready stall and never loops back from m_tready.
  always_comb begin
    passthru  = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    s_tready  = passthru ? m_tready : 1'b1;
    m_tvalid  = passthru && s_tvalid;
    m_tdata   = s_tdata;
    xfer      = s_tvalid && s_tready;
    trig_hit  = (state_q == ST_ARMED) && s_tvalid && (sel_evt || trig_force);
    last_post = (state_q == ST_POST) && s_tvalid;
    m_tlast   = !abort && (post_left_q == CNT_ONE) && (trig_hit || last_post);
    busy      = passthru;
    done      = (state_q == ST_DONE);
    trig_addr = trig_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    pre_left_d  = pre_left_q;
    post_left_d = post_left_q;
    trig_addr_d = trig_addr_q;
    sel_d       = sel_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            sel_d       = trig_sel_t'(trig_sel);
            pre_left_d  = pre_count;
            // post_left counts remaining post beats including the trigger beat
            post_left_d = (post_count == '0) ? CNT_ONE : post_count;
            beat_cnt_d  = '0;
            state_d     = (pre_count == '0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
            if (pre_left_q == CNT_ONE) state_d = ST_ARMED;
            else                       pre_left_d = pre_left_q - CNT_ONE;
          end
        end
        ST_ARMED: begin
          if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
            if (trig_hit) begin
              trig_addr_d = beat_cnt_q;
              if (post_left_q == CNT_ONE) begin
                state_d = ST_DONE;
              end else begin
                post_left_d = post_left_q - CNT_ONE;
                state_d     = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
            if (post_left_q == CNT_ONE) state_d = ST_DONE;
            else                        post_left_d = post_left_q - CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Scoreboard bench for trigger_capture_ctrl: a 16-bit and a 4-bit instance
// share stimulus; expected beats are queued and popped by a monitor.
module tb_trigger_capture_ctrl;
  import trigger_capture_pkg::*;

  logic        stream_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        m_tready = 1'b1;
  logic        ch1_rising = 1'b0, ch1_falling = 1'b0, ch2_rising = 1'b0, ch2_falling = 1'b0;
  logic [1:0]  trig_sel = '0;
  logic        trig_force = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [15:0] pre_count = '0, post_count = '0;

  logic        s_tready, m_tvalid, m_tlast, busy, done;
  logic [31:0] m_tdata;
  logic [15:0] trig_addr;
  logic        s_tready4, m_tvalid4, m_tlast4, busy4, done4;
  logic [31:0] m_tdata4;
  logic [3:0]  trig_addr4;

  always #5 stream_clk = ~stream_clk;

  trigger_capture_ctrl #(.CNT_WIDTH(16)) u_dut (
    .stream_clk(stream_clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .ch1_rising(ch1_rising), .ch1_falling(ch1_falling),
    .ch2_rising(ch2_rising), .ch2_falling(ch2_falling),
    .trig_sel(trig_sel), .trig_force(trig_force), .arm(arm), .abort(abort),
    .pre_count(pre_count), .post_count(post_count),
    .busy(busy), .done(done), .trig_addr(trig_addr)
  );

  trigger_capture_ctrl #(.CNT_WIDTH(4)) u_dut4 (
    .stream_clk(stream_clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready4), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid4), .m_tready(m_tready), .m_tdata(m_tdata4), .m_tlast(m_tlast4),
    .ch1_rising(ch1_rising), .ch1_falling(ch1_falling),
    .ch2_rising(ch2_rising), .ch2_falling(ch2_falling),
    .trig_sel(trig_sel), .trig_force(trig_force), .arm(arm), .abort(abort),
    .pre_count(pre_count[3:0]), .post_count(post_count[3:0]),
    .busy(busy4), .done(done4), .trig_addr(trig_addr4)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb4_q[$];
  exp_t e, e4;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stall_mode = 1'b0;
  bit   prev_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge stream_clk) begin
    if (m_tvalid && m_tready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected none", m_tdata, m_tlast);
      end else begin
        e = sb_q.pop_front();
        chk("beat_data", m_tdata, e.d);
        chk("beat_last", 32'(m_tlast), 32'(e.l));
      end
    end
    if (m_tvalid4 && m_tready) begin
      n_cmp++;
      if (sb4_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat4: got data %0h last %0b, expected none", m_tdata4, m_tlast4);
      end else begin
        e4 = sb4_q.pop_front();
        chk("beat4_data", m_tdata4, e4.d);
        chk("beat4_last", 32'(m_tlast4), 32'(e4.l));
      end
    end
    if (prev_hold) chk("tlast_hold", 32'(m_tlast), 32'd1);
    prev_hold = m_tvalid && m_tlast && !m_tready;
  end

  always @(posedge stream_clk) begin
    #1;
    m_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dat(input int s, input int i);
    return {16'(s), 16'(i)};
  endfunction

  task automatic tick();
    @(posedge stream_clk);
    #1;
  endtask

  // ev: [0] ch1_rising, [1] ch1_falling, [2] ch2_rising, [3] ch2_falling
  task automatic beat(input logic [31:0] d, input logic [3:0] ev, input bit frc,
                      input bit ab, input bit fwd, input bit lst);
    int  cyc;
    bit  got;
    if (stall_mode) repeat ($urandom_range(0, 2)) tick();
    if (fwd) begin
      sb_q.push_back('{d: d, l: lst});
      sb4_q.push_back('{d: d, l: lst});
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    {ch2_falling, ch2_rising, ch1_falling, ch1_rising} = ev;
    trig_force = frc;
    abort      = ab;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge stream_clk);
      got = s_tready;
      tick();
      cyc++;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: beat %0h not accepted, expected accept within 200 cycles", d);
    end
    s_tvalid = 1'b0;
    {ch2_falling, ch2_rising, ch1_falling, ch1_rising} = 4'b0;
    trig_force = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic arm_cfg(input int pre, input int post, input int sel);
    pre_count  = 16'(pre);
    post_count = 16'(post);
    trig_sel   = 2'(sel);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pre_count  = 16'hFFFF;
    post_count = 16'hFFFF;
    trig_sel   = 2'd3;
  endtask

  task automatic release_reset();
    resetn = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2;
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig_addr", trig_addr, 32'd0);
    repeat (3) tick();
    release_reset();

    // pre=4 post=8 sel=ch1_rising, trigger on beat 10; ch2_rising on 8 must be ignored
    arm_cfg(4, 8, 0);
    for (int i = 0; i < 18; i++) begin
      beat(dat(1, i), (i == 10) ? 4'b0001 : ((i == 8) ? 4'b0100 : 4'b0000), 1'b0, 1'b0, 1'b1, i == 17);
      if (i == 5) chk("s1_busy_mid", 32'(busy), 32'd1);
    end
    chk("s1_trig_addr", trig_addr, 32'd10);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);
    beat(dat(1, 18), 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // pre=4, triggers on beats 2 (in PRE) and 6; arm while busy is ignored
    arm_cfg(4, 3, 0);
    for (int i = 0; i < 9; i++) begin
      beat(dat(2, i), (i == 2 || i == 6) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b1, i == 8);
      if (i == 1) arm_cfg(0, 1, 2);
    end
    chk("s2_trig_addr", trig_addr, 32'd6);
    chk("s2_done", 32'(done), 32'd1);

    // pre=0 post=0 with trig_force: first beat is trigger and last
    trig_force = 1'b1;
    arm_cfg(0, 0, 0);
    beat(dat(3, 0), 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("s3_trig_addr", trig_addr, 32'd0);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_trig_addr4", 32'(trig_addr4), 32'd0);

    // random stalls, pre=2 post=5 sel=ch2_falling, trigger on beat 3
    stall_mode = 1'b1;
    arm_cfg(2, 5, 3);
    for (int i = 0; i < 8; i++)
      beat(dat(4, i), (i == 1 || i == 3) ? 4'b1000 : ((i == 5) ? 4'b0001 : 4'b0000),
           1'b0, 1'b0, 1'b1, i == 7);
    stall_mode = 1'b0;
    tick();
    chk("s4_trig_addr", trig_addr, 32'd3);
    chk("s4_done", 32'(done), 32'd1);

    // abort in ARMED together with a triggering transfer
    arm_cfg(0, 4, 1);
    beat(dat(5, 0), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(dat(5, 1), 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    chk("s5_trig_addr_kept", trig_addr, 32'd3);
    chk("s5_busy4", 32'(busy4), 32'd0);
    beat(dat(5, 2), 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

    // counter wrap: trigger on beat 20, 4-bit instance reports 4
    arm_cfg(0, 1, 2);
    for (int i = 0; i < 21; i++)
      beat(dat(6, i), (i == 20) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b1, i == 20);
    chk("s6_trig_addr", trig_addr, 32'd20);
    chk("s6_trig_addr4", 32'(trig_addr4), 32'd4);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_done4", 32'(done4), 32'd1);

    // reset in the middle of POST
    arm_cfg(1, 4, 0);
    beat(dat(7, 0), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(dat(7, 1), 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(dat(7, 2), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s7_busy_pre_rst", 32'(busy), 32'd1);
    s_tvalid = 1'b1;
    s_tdata  = dat(7, 3);
    resetn   = 1'b0;
    #1;
    chk("s7_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("s7_m_tlast", 32'(m_tlast), 32'd0);
    chk("s7_s_tready", 32'(s_tready), 32'd1);
    chk("s7_busy", 32'(busy), 32'd0);
    chk("s7_trig_addr", trig_addr, 32'd0);
    tick();
    s_tvalid = 1'b0;
    release_reset();
    chk("s7_done_after", 32'(done), 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("sb4_empty", sb4_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
